// File: rtl/uart_recv_if.sv
// Serial receive bundle: the line into the receiver and the byte/status it reports.
interface uart_recv_if;
  logic       uart_rxd;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       uart_frame_err;
  logic       uart_rx_busy;

  modport master (
    output uart_rxd,
    input  uart_data,
    input  uart_done,
    input  uart_frame_err,
    input  uart_rx_busy
  );

  modport slave (
    input  uart_rxd,
    output uart_data,
    output uart_done,
    output uart_frame_err,
    output uart_rx_busy
  );
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver: 3-flop line synchroniser, start-bit validation, mid-bit sampling,
// one-cycle done / framing-error strobes.
module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  uart_recv_if.slave  rx_bus
);

  localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_MID  = 16'(BPS_CNT / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  sync_q, sync_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;

  logic        start_edge_s;
  logic        mid_s;
  logic        last_s;
  logic        rx_bit_s;
  logic [15:0] cnt_next_s;

  assign rx_bit_s     = sync_q[1];
  assign start_edge_s = sync_q[2] & ~sync_q[1];
  assign mid_s        = (clk_cnt_q == CNT_MID);
  assign last_s       = (clk_cnt_q == CNT_LAST);
  assign cnt_next_s   = last_s ? 16'd0 : (clk_cnt_q + 16'd1);

  // State register; synchroniser presets high so reset release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 4'd0;
      sync_q    <= 3'b111;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, bit-period counter and bit counter.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sync_d    = {sync_q[1:0], rx_bus.uart_rxd};
    case (state_q)
      IDLE: begin
        clk_cnt_d = 16'd0;
        bit_cnt_d = 4'd0;
        if (start_edge_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        clk_cnt_d = cnt_next_s;
        if (mid_s && rx_bit_s) begin
          state_d   = IDLE;
          clk_cnt_d = 16'd0;
        end else if (last_s) begin
          state_d   = DATA;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        clk_cnt_d = cnt_next_s;
        if (last_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        // Leave half a bit early so a back-to-back start edge is not missed.
        if (mid_s) begin
          state_d   = IDLE;
          clk_cnt_d = 16'd0;
        end else begin
          state_d   = STOP;
          clk_cnt_d = cnt_next_s;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = 16'd0;
        bit_cnt_d = 4'd0;
      end
    endcase
  end

  // Data capture and status strobes.
  always_comb begin
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    if ((state_q == DATA) && mid_s) begin
      shift_d[bit_cnt_q[2:0]] = rx_bit_s;
    end else begin
      shift_d = shift_q;
    end
    if ((state_q == STOP) && mid_s) begin
      if (rx_bit_s) begin
        data_d = shift_q;
        done_d = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end else begin
      done_d = 1'b0;
      ferr_d = 1'b0;
    end
  end

  assign rx_bus.uart_data      = data_q;
  assign rx_bus.uart_done      = done_q;
  assign rx_bus.uart_frame_err = ferr_q;
  assign rx_bus.uart_rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: the model samples the recorded line history at mid-bit points
// relative to each recognised start edge; directed literals pin the model down.
module tb_uart_recv;
  localparam int CLK_FREQ = 2000000;
  localparam int UART_BPS = 100000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
  localparam int HALF     = BPS / 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  uart_recv_if rx_if();

  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_bus    (rx_if.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit p_hist[0:1023];

  bit         m_busy  = 1'b0;
  bit         m_stage = 1'b0;
  int         m_t0    = 0;
  logic [7:0] m_data  = 8'd0;

  int   done_cnt = 0;
  int   ferr_cnt = 0;
  int   busy_cyc = 0;
  int   last_done_cyc = 0;
  int   done_cycs[$];
  int   t0_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ph(input int c);
    return p_hist[c & 1023];
  endfunction

  // Reference receiver: frame outcome is read off the line history at k*BPS + BPS/2 offsets.
  always @(posedge sys_clk) begin : model_and_compare
    logic e_done, e_ferr, e_busy;
    cyc++;
    e_done = 1'b0;
    e_ferr = 1'b0;
    e_busy = 1'b0;
    if (!sys_rst_n) begin
      p_hist[cyc & 1023] = 1'b1;
      m_busy = 1'b0;
      m_data = 8'd0;
    end else begin
      p_hist[cyc & 1023] = rx_if.uart_rxd;
      if (m_busy && !m_stage && cyc == m_t0 + 3 + HALF) begin
        if (ph(m_t0 + 1 + HALF)) m_busy = 1'b0;
        else m_stage = 1'b1;
      end else if (m_busy && m_stage && cyc == m_t0 + 3 + 9 * BPS + HALF) begin
        if (ph(m_t0 + 1 + 9 * BPS + HALF)) begin
          for (int k = 0; k < 8; k++) m_data[k] = ph(m_t0 + 1 + (k + 1) * BPS + HALF);
          e_done = 1'b1;
        end else begin
          e_ferr = 1'b1;
        end
        m_busy = 1'b0;
      end
      if (!m_busy && ph(cyc - 2) && !ph(cyc - 1)) begin
        m_busy  = 1'b1;
        m_stage = 1'b0;
        m_t0    = cyc - 1;
      end
      e_busy = m_busy && (cyc >= m_t0 + 2);
    end
    #1;
    check("data", rx_if.uart_data, m_data);
    check("done", rx_if.uart_done, e_done);
    check("frame_err", rx_if.uart_frame_err, e_ferr);
    check("busy", rx_if.uart_rx_busy, e_busy);
    if (sys_rst_n) begin
      if (rx_if.uart_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        done_cycs.push_back(cyc);
      end
      if (rx_if.uart_frame_err) ferr_cnt++;
      if (rx_if.uart_rx_busy) busy_cyc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      rx_if.uart_rxd = 1'b1;
    end
  endtask

  // px10 is ten bit periods in clocks; 200 is exact, 192 is +4% baud, 208 is -4%.
  task automatic send_frame(input logic [7:0] d, input bit stop_v, input int px10);
    logic [9:0] bits;
    bits = {stop_v, d, 1'b0};
    for (int t = 0; t < px10; t++) begin
      @(negedge sys_clk);
      if (t == 0) t0_last = cyc + 1;
      rx_if.uart_rxd = bits[(t * 10) / px10];
    end
  endtask

  initial begin
    int d0, f0, b0, tfirst, px;
    logic [7:0] bytes4 [4];
    int pxs [3];
    bytes4 = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
    pxs    = '{200, 192, 208};
    for (int i = 0; i < 1024; i++) p_hist[i] = 1'b1;
    rx_if.uart_rxd = 1'b1;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_data", rx_if.uart_data, 8'h00);
    check("rst_done", rx_if.uart_done, 1'b0);
    check("rst_ferr", rx_if.uart_frame_err, 1'b0);
    check("rst_busy", rx_if.uart_rx_busy, 1'b0);
    sys_rst_n = 1'b1;
    idle(10);

    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, 200);
    idle(5);
    check("x55_done_cnt", done_cnt - d0, 1);
    check("x55_latency", last_done_cyc - t0_last, 9 * 20 + 10 + 3);
    check("x55_data", rx_if.uart_data, 8'h55);
    check("x55_ferr_cnt", ferr_cnt - f0, 0);

    done_cycs.delete();
    send_frame(8'hA3, 1'b1, 200);
    tfirst = t0_last;
    send_frame(8'h0F, 1'b1, 200);
    idle(5);
    check("b2b_count", done_cycs.size(), 2);
    if (done_cycs.size() == 2) begin
      check("b2b_first_lat", done_cycs[0] - tfirst, 193);
      check("b2b_spacing", done_cycs[1] - done_cycs[0], 200);
    end
    check("b2b_data", rx_if.uart_data, 8'h0F);

    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cyc;
    repeat (4) begin
      @(negedge sys_clk);
      rx_if.uart_rxd = 1'b0;
    end
    idle(40);
    check("glitch_busy_len", busy_cyc - b0, 11);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_data", rx_if.uart_data, 8'h0F);

    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 200);
    b0 = busy_cyc;
    repeat (300) begin
      @(negedge sys_clk);
      rx_if.uart_rxd = 1'b0;
    end
    check("ferr_cnt", ferr_cnt - f0, 1);
    check("ferr_done", done_cnt - d0, 0);
    check("ferr_data", rx_if.uart_data, 8'h0F);
    check("stuck_low_busy", busy_cyc - b0, 0);
    idle(5);
    send_frame(8'h66, 1'b1, 200);
    idle(5);
    check("recover_data", rx_if.uart_data, 8'h66);

    d0 = done_cnt; f0 = ferr_cnt;
    fork
      send_frame(8'hFF, 1'b1, 200);
      begin
        repeat (110) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_data", rx_if.uart_data, 8'h00);
        check("midrst_busy", rx_if.uart_rx_busy, 1'b0);
        check("midrst_done", rx_if.uart_done, 1'b0);
        check("midrst_ferr", rx_if.uart_frame_err, 1'b0);
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
      end
    join
    idle(20);
    check("aborted_done", done_cnt - d0, 0);
    check("aborted_ferr", ferr_cnt - f0, 0);
    send_frame(8'h81, 1'b1, 200);
    idle(5);
    check("after_rst_data", rx_if.uart_data, 8'h81);

    f0 = ferr_cnt;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        d0 = done_cnt;
        send_frame(bytes4[i], 1'b1, pxs[r]);
        idle(3);
        check("loop_done", done_cnt - d0, 1);
        check("loop_data", rx_if.uart_data, bytes4[i]);
      end
    end
    check("loop_ferr", ferr_cnt - f0, 0);

    for (int n = 0; n < 120; n++) begin
      int sel;
      sel = $urandom_range(0, 15);
      px  = pxs[$urandom_range(0, 2)];
      if (sel == 0) begin
        repeat ($urandom_range(1, 30)) begin
          @(negedge sys_clk);
          rx_if.uart_rxd = 1'b0;
        end
      end else if (sel == 1) begin
        fork
          send_frame(8'($urandom), 1'b1, px);
          begin
            repeat ($urandom_range(1, 180)) @(negedge sys_clk);
            sys_rst_n = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge sys_clk);
            sys_rst_n = 1'b1;
          end
        join
      end else begin
        send_frame(8'($urandom), ($urandom_range(0, 7) != 0), px);
      end
      idle($urandom_range(0, 25));
    end
    idle(250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
